// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : soc_pkg
//  Purpose  : Shared types and constants for the Clause-22 MDIO responder.
//  Revision : 1.0 - initial release
// ============================================================================
package soc_pkg;

    typedef enum logic [2:0] {
        MDIO_S_IDLE  = 3'd0,
        MDIO_S_ST    = 3'd1,
        MDIO_S_OP    = 3'd2,
        MDIO_S_PHYAD = 3'd3,
        MDIO_S_REGAD = 3'd4,
        MDIO_S_TA    = 3'd5,
        MDIO_S_DATA  = 3'd6
    } mdio_state_e;

    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;

    localparam logic [4:0] MDIO_REG_BMCR = 5'd0;
    localparam logic [4:0] MDIO_REG_BMSR = 5'd1;
    localparam logic [4:0] MDIO_REG_ID1  = 5'd2;
    localparam logic [4:0] MDIO_REG_ID2  = 5'd3;

    function automatic logic mdio_op_valid(input logic [1:0] op);
        return (op == MDIO_OP_RD) || (op == MDIO_OP_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_sync_edge
//  Purpose  : Two-flop synchronizers for MDC/MDIO plus MDC rising-edge detect.
//  Revision : 1.0 - initial release
// ============================================================================
module mdio_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [1:0] r_mdc_sync;
    logic       r_mdc_prev;
    logic [1:0] r_mdio_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mdc_sync  <= 2'b00;
            r_mdc_prev  <= 1'b0;
            r_mdio_sync <= 2'b00;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[0], mdc_i};
            r_mdc_prev  <= r_mdc_sync[1];
            r_mdio_sync <= {r_mdio_sync[0], mdio_i};
        end
    end

    assign mdc_rise = r_mdc_sync[1] & ~r_mdc_prev;
    assign mdio_s   = r_mdio_sync[1];

endmodule
`default_nettype wire

// File: rtl/mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_responder
//  Purpose  : PHY-side Clause-22 MDIO frame decoder with 16-bit register file.
//             Optional macro MDIO_RESP_PREAMBLE_SUPPRESS_EN enables preamble
//             suppression after a completed frame.
//  Revision : 1.0 - initial release
// ============================================================================
module mdio_responder
    import soc_pkg::*;
#(
    parameter int          NUM_REGS     = 32,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [31:0] PHY_ID       = 32'h001C_C915,
    parameter logic [15:0] BMCR_RST     = 16'h1140,
    parameter logic [15:0] BMSR_BASE    = 16'h7949
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  phy_addr,
    input  logic        link_up,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        reg_wr_stb,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_err
);

    localparam int                 c_PRE_W   = $clog2(PREAMBLE_LEN + 1);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PREAMBLE_LEN);

    logic w_rise;
    logic w_bit;

    mdio_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc_i    (mdc_i),
        .mdio_i   (mdio_i),
        .mdc_rise (w_rise),
        .mdio_s   (w_bit)
    );

    mdio_state_e        r_state;
    mdio_state_e        w_state_next;
    logic [4:0]         r_bit_cnt;
    logic [c_PRE_W-1:0] r_pre_cnt;
    logic [1:0]         r_op;
    logic [4:0]         r_addr_sr;
    logic               r_match;
    logic [4:0]         r_regad;
    logic [15:0]        r_rd_sr;
    logic [14:0]        r_wr_sr;
    logic [15:0]        r_regs [32];

    logic               r_mdio_o;
    logic               r_mdio_oe;
    logic               r_wr_stb;
    logic [4:0]         r_wr_addr;
    logic [15:0]        r_wr_data;
    logic               r_frame_err;

    logic               w_last;
    logic [1:0]         w_op_next;
    logic [4:0]         w_addr_next;
    logic [15:0]        w_wr_data;
    logic [15:0]        w_rd_data;
    logic               w_drive;
    logic               w_pre_ok;
    logic               w_err;
    logic               w_done;
    logic               w_wr_fire;

    assign w_last      = (r_bit_cnt == 5'd0);
    assign w_op_next   = {r_op[0], w_bit};
    assign w_addr_next = {r_addr_sr[3:0], w_bit};
    assign w_wr_data   = {r_wr_sr, w_bit};
    assign w_drive     = (r_op == MDIO_OP_RD) && r_match;
    assign w_wr_fire   = w_rise && (r_state == MDIO_S_DATA) && w_last &&
                         (r_op == MDIO_OP_WR) && r_match &&
                         (32'(r_regad) < NUM_REGS);

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    // Cleared by reset and by frame_err so the next frame needs a full preamble.
    logic r_sup_ok;

    always_ff @(posedge clk) begin
        if (!rst_n)      r_sup_ok <= 1'b0;
        else if (w_err)  r_sup_ok <= 1'b0;
        else if (w_done) r_sup_ok <= 1'b1;
    end

    assign w_pre_ok = (r_pre_cnt == c_PRE_MAX) || (r_sup_ok && (r_pre_cnt != '0));
`else
    assign w_pre_ok = (r_pre_cnt == c_PRE_MAX);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= MDIO_S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_done       = 1'b0;
        if (w_rise) begin
            case (r_state)
                MDIO_S_IDLE: begin
                    if (!w_bit && w_pre_ok) w_state_next = MDIO_S_ST;
                end
                MDIO_S_ST: begin
                    if (w_bit) begin
                        w_state_next = MDIO_S_OP;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = MDIO_S_IDLE;
                    end
                end
                MDIO_S_OP: begin
                    if (w_last) begin
                        if (mdio_op_valid(w_op_next)) begin
                            w_state_next = MDIO_S_PHYAD;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = MDIO_S_IDLE;
                        end
                    end
                end
                MDIO_S_PHYAD: begin
                    if (w_last) w_state_next = MDIO_S_REGAD;
                end
                MDIO_S_REGAD: begin
                    if (w_last) w_state_next = MDIO_S_TA;
                end
                MDIO_S_TA: begin
                    // Write turnaround must be 1 then 0; bit_cnt[0] is the expected value.
                    if ((r_op == MDIO_OP_WR) && (w_bit != r_bit_cnt[0])) begin
                        w_err        = r_match;
                        w_state_next = MDIO_S_IDLE;
                    end else if (w_last) begin
                        w_state_next = MDIO_S_DATA;
                    end
                end
                MDIO_S_DATA: begin
                    if (w_last) begin
                        w_done       = 1'b1;
                        w_state_next = MDIO_S_IDLE;
                    end
                end
                default: w_state_next = MDIO_S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (32'(w_addr_next) < NUM_REGS) begin
            case (w_addr_next)
                MDIO_REG_BMCR: w_rd_data = {1'b0, r_regs[0][14:0]};
                MDIO_REG_BMSR: w_rd_data = {BMSR_BASE[15:3], link_up, BMSR_BASE[1:0]};
                MDIO_REG_ID1:  w_rd_data = PHY_ID[31:16];
                MDIO_REG_ID2:  w_rd_data = PHY_ID[15:0];
                default:       w_rd_data = r_regs[w_addr_next];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_op        <= '0;
            r_addr_sr   <= '0;
            r_match     <= 1'b0;
            r_regad     <= '0;
            r_rd_sr     <= '0;
            r_wr_sr     <= '0;
            r_mdio_o    <= 1'b0;
            r_mdio_oe   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_rise) begin
                case (r_state)
                    MDIO_S_IDLE: begin
                        if (!w_bit)                         r_pre_cnt <= '0;
                        else if (r_pre_cnt != c_PRE_MAX)    r_pre_cnt <= r_pre_cnt + 1'b1;
                    end
                    MDIO_S_ST: begin
                        r_bit_cnt <= 5'd1;
                    end
                    MDIO_S_OP: begin
                        r_op      <= w_op_next;
                        r_bit_cnt <= w_last ? 5'd4 : r_bit_cnt - 1'b1;
                    end
                    MDIO_S_PHYAD: begin
                        r_addr_sr <= w_addr_next;
                        r_bit_cnt <= w_last ? 5'd4 : r_bit_cnt - 1'b1;
                        if (w_last) r_match <= (w_addr_next == phy_addr);
                    end
                    MDIO_S_REGAD: begin
                        r_addr_sr <= w_addr_next;
                        r_bit_cnt <= w_last ? 5'd1 : r_bit_cnt - 1'b1;
                        if (w_last) begin
                            r_regad <= w_addr_next;
                            r_rd_sr <= w_rd_data;
                        end
                    end
                    MDIO_S_TA: begin
                        r_bit_cnt <= w_last ? 5'd15 : r_bit_cnt - 1'b1;
                        if (w_drive) begin
                            // TA1 rise: take the bus driving 0; TA2 rise: present D15.
                            if (!w_last) begin
                                r_mdio_oe <= 1'b1;
                                r_mdio_o  <= 1'b0;
                            end else begin
                                r_mdio_o <= r_rd_sr[15];
                                r_rd_sr  <= {r_rd_sr[14:0], 1'b0};
                            end
                        end
                    end
                    MDIO_S_DATA: begin
                        r_wr_sr   <= w_wr_data[14:0];
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        if (w_drive) begin
                            if (w_last) begin
                                r_mdio_oe <= 1'b0;
                                r_mdio_o  <= 1'b0;
                            end else begin
                                r_mdio_o <= r_rd_sr[15];
                                r_rd_sr  <= {r_rd_sr[14:0], 1'b0};
                            end
                        end
                        if (w_done) r_pre_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? BMCR_RST : 16'h0000;
        end else begin
            r_wr_stb <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr <= r_regad;
                r_wr_data <= w_wr_data;
                if (r_regad == MDIO_REG_BMCR) begin
                    // Soft reset: restore RW registers, ignore the other written bits.
                    if (w_wr_data[15]) begin
                        for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? BMCR_RST : 16'h0000;
                    end else begin
                        r_regs[0] <= w_wr_data;
                    end
                end else if (r_regad >= 5'd4) begin
                    r_regs[r_regad] <= w_wr_data;
                end
            end
        end
    end

    assign mdio_o      = r_mdio_o;
    assign mdio_oe     = r_mdio_oe;
    assign reg_wr_stb  = r_wr_stb;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdio_responder
//  Purpose  : Directed self-checking bench for mdio_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_responder;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [4:0]  phy_addr = 5'd1;
    logic        link_up  = 1'b0;
    logic        mdc_i    = 1'b0;
    logic        mdio_i   = 1'b1;
    logic        mdio_o;
    logic        mdio_oe;
    logic        reg_wr_stb;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        frame_err;

    mdio_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phy_addr    (phy_addr),
        .link_up     (link_up),
        .mdc_i       (mdc_i),
        .mdio_i      (mdio_i),
        .mdio_o      (mdio_o),
        .mdio_oe     (mdio_oe),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int          wr_cnt  = 0;
    int          err_cyc = 0;
    int          oe_cyc  = 0;
    logic [4:0]  last_addr = '0;
    logic [15:0] last_data = '0;

    always @(negedge clk) begin
        if (reg_wr_stb) begin
            wr_cnt++;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (frame_err) err_cyc++;
        if (mdio_oe)   oe_cyc++;
    end

    logic        g_ta1_oe, g_ta2_oe, g_ta2_o, g_oe_all, g_oe_after;
    logic [15:0] g_rd;

    // One MDC period: drive during low phase, sample DUT just before the rise.
    task automatic mdc_bit(input logic b, output logic so, output logic soe);
        mdio_i = b;
        mdc_i  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        so    = mdio_o;
        soe   = mdio_oe;
        mdc_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic so, soe;
        for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], so, soe);
    endtask

    task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] wd);
        logic so, soe;
        send_bits(32'hFFFF_FFFF, pre);
        send_bits({18'b0, 2'b01, op, pa, ra}, 14);
        if (op == 2'b01) begin
            send_bits(32'h2, 2);
            send_bits({16'b0, wd}, 16);
        end else begin
            mdc_bit(1'b1, so, soe); g_ta1_oe = soe;
            mdc_bit(1'b1, so, soe); g_ta2_o = so; g_ta2_oe = soe;
            g_rd = '0; g_oe_all = 1'b1;
            for (int i = 15; i >= 0; i--) begin
                mdc_bit(1'b1, so, soe);
                g_rd[i]  = so;
                g_oe_all = g_oe_all & soe;
            end
            mdc_bit(1'b1, so, soe); g_oe_after = soe;
        end
    endtask

    task automatic apply_reset();
        mdc_i  = 1'b0;
        mdio_i = 1'b1;
        rst_n  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (mdio_oe !== 1'b0)      begin n_errors++; $display("FAIL reset_oe: got %b expected 0", mdio_oe); end
        n_checks++; if (mdio_o !== 1'b0)       begin n_errors++; $display("FAIL reset_o: got %b expected 0", mdio_o); end
        n_checks++; if (reg_wr_stb !== 1'b0)   begin n_errors++; $display("FAIL reset_stb: got %b expected 0", reg_wr_stb); end
        n_checks++; if (frame_err !== 1'b0)    begin n_errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        n_checks++; if (reg_wr_addr !== 5'd0)  begin n_errors++; $display("FAIL reset_addr: got %h expected 00", reg_wr_addr); end
        n_checks++; if (reg_wr_data !== 16'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0000", reg_wr_data); end
    endtask

    task automatic test_write_read();
        int w0, e0;
        w0 = wr_cnt; e0 = err_cyc;
        do_frame(32, 2'b01, 5'd1, 5'd5, 16'h1234);
        repeat (3) @(posedge clk);
        n_checks++; if (wr_cnt - w0 !== 1)     begin n_errors++; $display("FAIL wr_stb_count: got %0d expected 1", wr_cnt - w0); end
        n_checks++; if (last_addr !== 5'd5)    begin n_errors++; $display("FAIL wr_addr: got %h expected 05", last_addr); end
        n_checks++; if (last_data !== 16'h1234) begin n_errors++; $display("FAIL wr_data: got %h expected 1234", last_data); end
        n_checks++; if (err_cyc - e0 !== 0)    begin n_errors++; $display("FAIL wr_no_err: got %0d expected 0", err_cyc - e0); end
        do_frame(32, 2'b10, 5'd1, 5'd5, 16'h0);
        n_checks++; if (g_rd !== 16'h1234)     begin n_errors++; $display("FAIL rd_reg5: got %h expected 1234", g_rd); end
    endtask

    task automatic test_read_id();
        int o0;
        o0 = oe_cyc;
        do_frame(32, 2'b10, 5'd1, 5'd2, 16'h0);
        n_checks++; if (g_ta1_oe !== 1'b0)     begin n_errors++; $display("FAIL ta1_oe: got %b expected 0", g_ta1_oe); end
        n_checks++; if (g_ta2_oe !== 1'b1)     begin n_errors++; $display("FAIL ta2_oe: got %b expected 1", g_ta2_oe); end
        n_checks++; if (g_ta2_o !== 1'b0)      begin n_errors++; $display("FAIL ta2_o: got %b expected 0", g_ta2_o); end
        n_checks++; if (g_rd !== 16'h001C)     begin n_errors++; $display("FAIL rd_id1: got %h expected 001c", g_rd); end
        n_checks++; if (g_oe_all !== 1'b1)     begin n_errors++; $display("FAIL oe_during_data: got %b expected 1", g_oe_all); end
        n_checks++; if (g_oe_after !== 1'b0)   begin n_errors++; $display("FAIL oe_after_d0: got %b expected 0", g_oe_after); end
        n_checks++; if (oe_cyc - o0 !== 170)   begin n_errors++; $display("FAIL oe_clk_cycles: got %0d expected 170", oe_cyc - o0); end
        do_frame(32, 2'b10, 5'd1, 5'd3, 16'h0);
        n_checks++; if (g_rd !== 16'hC915)     begin n_errors++; $display("FAIL rd_id2: got %h expected c915", g_rd); end
        link_up = 1'b1;
        do_frame(32, 2'b10, 5'd1, 5'd1, 16'h0);
        n_checks++; if (g_rd !== 16'h794D)     begin n_errors++; $display("FAIL rd_bmsr_up: got %h expected 794d", g_rd); end
        link_up = 1'b0;
        do_frame(32, 2'b10, 5'd1, 5'd1, 16'h0);
        n_checks++; if (g_rd !== 16'h7949)     begin n_errors++; $display("FAIL rd_bmsr_down: got %h expected 7949", g_rd); end
        do_frame(32, 2'b10, 5'd1, 5'd0, 16'h0);
        n_checks++; if (g_rd !== 16'h1140)     begin n_errors++; $display("FAIL rd_bmcr: got %h expected 1140", g_rd); end
    endtask

    task automatic test_other_phy();
        int w0, e0, o0;
        w0 = wr_cnt; e0 = err_cyc; o0 = oe_cyc;
        do_frame(32, 2'b01, 5'd3, 5'd5, 16'hFFFF);
        do_frame(32, 2'b10, 5'd3, 5'd2, 16'h0);
        n_checks++; if (wr_cnt - w0 !== 0)     begin n_errors++; $display("FAIL other_phy_stb: got %0d expected 0", wr_cnt - w0); end
        n_checks++; if (err_cyc - e0 !== 0)    begin n_errors++; $display("FAIL other_phy_err: got %0d expected 0", err_cyc - e0); end
        n_checks++; if (oe_cyc - o0 !== 0)     begin n_errors++; $display("FAIL other_phy_oe: got %0d expected 0", oe_cyc - o0); end
        do_frame(32, 2'b10, 5'd1, 5'd5, 16'h0);
        n_checks++; if (g_rd !== 16'h1234)     begin n_errors++; $display("FAIL other_phy_reg5: got %h expected 1234", g_rd); end
    endtask

    task automatic test_bmcr_reset();
        int w0;
        do_frame(32, 2'b01, 5'd1, 5'd0, 16'h3100);
        do_frame(32, 2'b10, 5'd1, 5'd0, 16'h0);
        n_checks++; if (g_rd !== 16'h3100)     begin n_errors++; $display("FAIL bmcr_rw: got %h expected 3100", g_rd); end
        w0 = wr_cnt;
        do_frame(32, 2'b01, 5'd1, 5'd2, 16'hFFFF);
        repeat (3) @(posedge clk);
        n_checks++; if (wr_cnt - w0 !== 1)     begin n_errors++; $display("FAIL ro_write_stb: got %0d expected 1", wr_cnt - w0); end
        do_frame(32, 2'b10, 5'd1, 5'd2, 16'h0);
        n_checks++; if (g_rd !== 16'h001C)     begin n_errors++; $display("FAIL ro_unchanged: got %h expected 001c", g_rd); end
        do_frame(32, 2'b01, 5'd1, 5'd5, 16'hBEEF);
        do_frame(32, 2'b10, 5'd1, 5'd5, 16'h0);
        n_checks++; if (g_rd !== 16'hBEEF)     begin n_errors++; $display("FAIL reg5_beef: got %h expected beef", g_rd); end
        do_frame(32, 2'b01, 5'd1, 5'd0, 16'h8000);
        do_frame(32, 2'b10, 5'd1, 5'd5, 16'h0);
        n_checks++; if (g_rd !== 16'h0000)     begin n_errors++; $display("FAIL soft_rst_reg5: got %h expected 0000", g_rd); end
        do_frame(32, 2'b10, 5'd1, 5'd0, 16'h0);
        n_checks++; if (g_rd !== 16'h1140)     begin n_errors++; $display("FAIL soft_rst_bmcr: got %h expected 1140", g_rd); end
    endtask

    task automatic test_bad_op();
        int w0, e0, o0;
        w0 = wr_cnt; e0 = err_cyc; o0 = oe_cyc;
        do_frame(32, 2'b11, 5'd1, 5'd2, 16'h0);
        n_checks++; if (err_cyc - e0 !== 1)    begin n_errors++; $display("FAIL bad_op_err: got %0d expected 1", err_cyc - e0); end
        n_checks++; if (oe_cyc - o0 !== 0)     begin n_errors++; $display("FAIL bad_op_oe: got %0d expected 0", oe_cyc - o0); end
        n_checks++; if (wr_cnt - w0 !== 0)     begin n_errors++; $display("FAIL bad_op_stb: got %0d expected 0", wr_cnt - w0); end
        do_frame(32, 2'b10, 5'd1, 5'd2, 16'h0);
        n_checks++; if (g_rd !== 16'h001C)     begin n_errors++; $display("FAIL after_bad_op: got %h expected 001c", g_rd); end
    endtask

    task automatic test_back_to_back();
        int w0;
        logic [15:0] exp_rd;
        int          exp_wr;
        w0 = wr_cnt;
        do_frame(32, 2'b01, 5'd1, 5'd6, 16'h1111);
        do_frame(1,  2'b01, 5'd1, 5'd6, 16'h2222);
        repeat (3) @(posedge clk);
`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
        exp_wr = 2; exp_rd = 16'h2222;
`else
        exp_wr = 1; exp_rd = 16'h1111;
`endif
        n_checks++; if (wr_cnt - w0 !== exp_wr) begin n_errors++; $display("FAIL b2b_stb: got %0d expected %0d", wr_cnt - w0, exp_wr); end
        do_frame(32, 2'b10, 5'd1, 5'd6, 16'h0);
        n_checks++; if (g_rd !== exp_rd)       begin n_errors++; $display("FAIL b2b_reg6: got %h expected %h", g_rd, exp_rd); end
    endtask

    task automatic test_short_preamble();
        int w0, e0;
        apply_reset();
        w0 = wr_cnt; e0 = err_cyc;
        do_frame(31, 2'b01, 5'd1, 5'd5, 16'hAAAA);
        repeat (3) @(posedge clk);
        n_checks++; if (wr_cnt - w0 !== 0)     begin n_errors++; $display("FAIL short_pre_stb: got %0d expected 0", wr_cnt - w0); end
        n_checks++; if (err_cyc - e0 !== 0)    begin n_errors++; $display("FAIL short_pre_err: got %0d expected 0", err_cyc - e0); end
        do_frame(32, 2'b10, 5'd1, 5'd5, 16'h0);
        n_checks++; if (g_rd !== 16'h0000)     begin n_errors++; $display("FAIL short_pre_reg5: got %h expected 0000", g_rd); end
    endtask

    task automatic test_reset_mid_read();
        logic so, soe;
        do_frame(32, 2'b01, 5'd1, 5'd5, 16'h5555);
        send_bits(32'hFFFF_FFFF, 32);
        send_bits({18'b0, 2'b01, 2'b10, 5'd1, 5'd5}, 14);
        mdc_bit(1'b1, so, soe);
        mdc_bit(1'b1, so, soe);
        for (int i = 0; i < 3; i++) mdc_bit(1'b1, so, soe);
        n_checks++; if (mdio_oe !== 1'b1)      begin n_errors++; $display("FAIL mid_read_oe: got %b expected 1", mdio_oe); end
        rst_n = 1'b0;
        mdc_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (mdio_oe !== 1'b0)      begin n_errors++; $display("FAIL rst_oe_release: got %b expected 0", mdio_oe); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_frame(32, 2'b10, 5'd1, 5'd5, 16'h0);
        n_checks++; if (g_rd !== 16'h0000)     begin n_errors++; $display("FAIL rst_reg5: got %h expected 0000", g_rd); end
        do_frame(32, 2'b10, 5'd1, 5'd0, 16'h0);
        n_checks++; if (g_rd !== 16'h1140)     begin n_errors++; $display("FAIL rst_bmcr: got %h expected 1140", g_rd); end
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_read_id();
        test_other_phy();
        test_bmcr_reset();
        test_bad_op();
        test_back_to_back();
        test_short_preamble();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
